draw_rect: RTL and testbench
============================

Name: draw_rect

Overview:
- Pixel-pipeline stage directly downstream of draw_rect_ctl.
- Overlays a solid rectangle on the incoming VGA timing and RGB stream, with the rectangle's top edge at draw_rect_ctl's ypos output.
- Sits between the background generator and the VGA output register.
- ypos is captured once per frame at blanking start, so the rectangle never tears mid-frame.

Parameters:
- XPOS, 100, left column of the rectangle in pixels.
- WIDTH, 48, rectangle width in pixels (>=1).
- HEIGHT, 64, rectangle height in pixels (>=1).
- RECT_RGB, 12'hF80, rectangle fill colour (4:4:4).
- BORDER_RGB, 12'hFFF, outline colour (used only with the optional feature).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-low
- ypos  in  12  rectangle top row from draw_rect_ctl; any cycle, sampled only at the latch point
- hcount_in  in  11  horizontal pixel counter
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vcount_in  in  11  vertical line counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background pixel colour
- hcount_out  out  11  hcount_in delayed by 2
- hsync_out  out  1  hsync_in delayed by 2
- hblnk_out  out  1  hblnk_in delayed by 2
- vcount_out  out  11  vcount_in delayed by 2
- vsync_out  out  1  vsync_in delayed by 2
- vblnk_out  out  1  vblnk_in delayed by 2
- rgb_out  out  12  composited pixel

Behaviour:
- Reset (rst==0 at a clk edge): all outputs, all pipeline registers and ypos_lat go to 0. Takes effect on the next edge even mid-frame. The first frame after reset draws at row 0 until the first latch point.
- Latency: fixed 2 cycles on every output; all six timing signals are delayed identically to rgb.
- Position latch: ypos_lat <= ypos when vcount_in==VER_PIXELS and hcount_in==0 (first blank line, from vga_pkg). Otherwise ypos_lat holds. A ypos change at any other time affects only the next frame.
- Stage 1:
  - Register the timing inputs and rgb_in.
  - hit_x = (hcount_in >= XPOS) && (hcount_in < XPOS+WIDTH).
  - hit_y = (vcount_in >= ypos_lat) && (vcount_in < ypos_lat+HEIGHT).
  - Comparisons are evaluated at 13 bits so that ypos_lat+HEIGHT cannot wrap.
- Stage 2:
  - If blank (hblnk or vblnk of stage 1), rgb_out = 12'h000.
  - Else if hit_x && hit_y, rgb_out = RECT_RGB.
  - Else rgb_out = stage-1 rgb.
- Clipping: a rectangle extending past VER_PIXELS-1 or HOR_PIXELS-1 is drawn only on visible pixels. ypos_lat >= VER_PIXELS draws nothing. No wrap to the top of the screen.
- The rectangle is drawn on ypos_lat exactly as latched; no state other than ypos_lat persists across frames.

Optional Feature:
- Macro: DRAW_RECT_BORDER_EN.
- Defined: 1-pixel outline in BORDER_RGB on hit pixels where hcount==XPOS, hcount==XPOS+WIDTH-1, vcount==ypos_lat or vcount==ypos_lat+HEIGHT-1. Interior stays RECT_RGB. Clipping rules are unchanged; a clipped edge gets no border.
- Undefined: the whole rectangle is RECT_RGB. Latency remains 2 cycles in both builds.

Test Plan:
- Reset mid-line: hold rst=0 for 3 cycles while streaming -> all outputs 0 on the edge after rst is sampled low. Pipeline refills with 2-cycle latency after release.
- Latency/pass-through: ypos=700 latched, random timing stream -> every *_out equals its *_in from 2 cycles earlier. rgb_out equals rgb_in when not blank, and 0 when blank.
- Basic hit, ypos=200 latched: pixel (100,200) -> F80; (147,263) -> F80; (99,200) -> rgb_in; (148,200) -> rgb_in; (100,264) -> rgb_in.
- Frame-latch timing: change ypos from 200 to 300 at vcount=250 -> rows 200..263 drawn for the rest of the frame. The next frame draws rows 300..363.
- Bottom clip, ypos=570 latched (VER_PIXELS=600): rows 570..599 drawn. No rectangle pixels at vcount 0..33 of the following frame. ypos=4095 -> nothing drawn.
- With DRAW_RECT_BORDER_EN, ypos=200: (100,220) -> FFF; (120,200) -> FFF; (147,263) -> FFF; (120,220) -> F80.

Source files
------------

// File: rtl/draw_rect.sv
// Overlays a solid rectangle on the VGA pixel stream with a fixed two-cycle latency.
// Optional macro DRAW_RECT_BORDER_EN adds a 1-pixel outline in BORDER_RGB.
module draw_rect #(
  parameter int          XPOS       = 100,
  parameter int          WIDTH      = 48,
  parameter int          HEIGHT     = 64,
  parameter logic [11:0] RECT_RGB   = 12'hF80,
  parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int          VER_PIXELS = 600;
  localparam logic [12:0] X_LO       = 13'(XPOS);
  localparam logic [12:0] X_HI       = 13'(XPOS + WIDTH);
  localparam logic [12:0] H_13       = 13'(HEIGHT);

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } pix_t;

  pix_t        s1_d, s1_q, out_d, out_q;
  logic        hit_d, hit_q;
  logic        border_d, border_q;
  logic [11:0] ypos_lat_d, ypos_lat_q;

  logic [12:0] h_13, v_13, y_lo, y_hi;
  logic        hit_x, hit_y;

  always_comb begin
    ypos_lat_d = ypos_lat_q;
    // The first blank line is the only point where the position may change.
    if (vcount_in == 11'(VER_PIXELS) && hcount_in == 11'd0) begin
      ypos_lat_d = ypos;
    end

    s1_d = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
             vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in};

    // 13-bit arithmetic keeps ypos_lat + HEIGHT from wrapping back to the top.
    h_13  = {2'b00, hcount_in};
    v_13  = {2'b00, vcount_in};
    y_lo  = {1'b0, ypos_lat_q};
    y_hi  = y_lo + H_13;
    hit_x = (h_13 >= X_LO) && (h_13 < X_HI);
    hit_y = (v_13 >= y_lo) && (v_13 < y_hi);
    hit_d = hit_x && hit_y;

`ifdef DRAW_RECT_BORDER_EN
    border_d = hit_d && ((h_13 == X_LO) || (h_13 == X_HI - 13'd1) ||
                         (v_13 == y_lo) || (v_13 == y_hi - 13'd1));
`else
    border_d = 1'b0;
`endif

    out_d = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (hit_q) begin
      out_d.rgb = border_q ? BORDER_RGB : RECT_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ypos_lat_q <= '0;
      s1_q       <= '0;
      hit_q      <= 1'b0;
      border_q   <= 1'b0;
      out_q      <= '0;
    end else begin
      ypos_lat_q <= ypos_lat_d;
      s1_q       <= s1_d;
      hit_q      <= hit_d;
      border_q   <= border_d;
      out_q      <= out_d;
    end
  end

  assign hcount_out = out_q.hcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign vcount_out = out_q.vcount;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_rect.sv
// Scoreboard bench for draw_rect: expected pixels are queued at drive time and
// compared when they emerge two cycles later.
module tb_draw_rect;

  localparam int          XPOS       = 100;
  localparam int          WIDTH      = 48;
  localparam int          HEIGHT     = 64;
  localparam int          VER_PIXELS = 600;
  localparam int          HOR_PIXELS = 800;
  localparam logic [11:0] RECT_RGB   = 12'hF80;
  localparam logic [11:0] BORDER_RGB = 12'hFFF;
  localparam int          W          = 38;

  logic        clk, rst;
  logic [11:0] ypos;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;

  draw_rect dut (
    .clk(clk), .rst(rst), .ypos(ypos),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [W-1:0]  exp_q[$];
  string         tag_q[$];
  int            lat_m;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] rgb, input int lat);
    logic hit;
    if (hb || vb) return 12'h000;
    hit = (h >= XPOS) && (h < XPOS + WIDTH) && (v >= lat) && (v < lat + HEIGHT);
    if (!hit) return rgb;
`ifdef DRAW_RECT_BORDER_EN
    if (h == XPOS || h == XPOS + WIDTH - 1 || v == lat || v == lat + HEIGHT - 1) return BORDER_RGB;
`endif
    return RECT_RGB;
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
  endfunction

  // driver: one pixel per cycle, scoreboard push then pop of the emerging pixel
  task automatic step(input int h, input int v, input logic hs, input logic hb,
                      input logic vs, input logic vb, input logic [11:0] rgb, input string tag);
    logic [W-1:0] e;
    string        t;
    hcount_in = h[10:0];
    vcount_in = v[10:0];
    hsync_in  = hs;
    hblnk_in  = hb;
    vsync_in  = vs;
    vblnk_in  = vb;
    rgb_in    = rgb;
    exp_q.push_back({h[10:0], hs, hb, v[10:0], vs, vb, model_rgb(h, v, hb, vb, rgb, lat_m)});
    tag_q.push_back(tag);
    if (v == VER_PIXELS && h == 0) lat_m = int'(ypos);
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, dut_out(), e);
    end
  endtask

  task automatic pix(input int h, input int v, input string tag);
    step(h, v, 1'b0, (h >= HOR_PIXELS), 1'b0, (v >= VER_PIXELS),
         12'($urandom_range(0, 4095)), tag);
  endtask

  task automatic latch_ypos(input int y);
    ypos = 12'(y);
    pix(0, VER_PIXELS, "latch");
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      hcount_in = 11'($urandom_range(0, 1055));
      vcount_in = 11'($urandom_range(0, 627));
      hsync_in  = 1'($urandom_range(0, 1));
      hblnk_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      vblnk_in  = 1'($urandom_range(0, 1));
      rgb_in    = 12'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
      check_eq("reset_zero", dut_out(), '0);
    end
    exp_q.delete();
    tag_q.delete();
    lat_m = 0;
    // stage 1 was cleared by reset, so the first pixel out after release is all zero
    exp_q.push_back('0);
    tag_q.push_back("refill");
    rst = 1'b1;
  endtask

  initial begin
    int h, v;
    ypos = 12'd0;
    do_reset(3);

    // pass-through with the rectangle parked below the screen
    latch_ypos(700);
    for (int i = 0; i < 150; i++) begin
      h = $urandom_range(0, 1055);
      v = $urandom_range(0, 627);
      step(h, v, 1'($urandom_range(0, 1)), (h >= HOR_PIXELS), 1'($urandom_range(0, 1)),
           (v >= VER_PIXELS), 12'($urandom_range(0, 4095)), "passthru");
    end

    // basic hit and edges
    latch_ypos(200);
    pix(100, 200, "hit_tl");
    pix(147, 263, "hit_br");
    pix(99, 200, "miss_left");
    pix(148, 200, "miss_right");
    pix(100, 264, "miss_below");
    pix(100, 220, "left_edge");
    pix(120, 200, "top_edge");
    pix(120, 220, "interior");
    pix(850, 220, "hblank");

    // reset mid-line, then the first frame draws at row 0
    for (int i = 0; i < 4; i++) pix(90 + i * 10, 210, "pre_reset");
    do_reset(3);
    pix(100, 0, "rst_row0");
    pix(120, 63, "rst_row63");
    pix(120, 64, "rst_row64");

    // ypos changes mid-frame only take effect at the next latch point
    latch_ypos(200);
    pix(120, 250, "frame_a");
    ypos = 12'd300;
    pix(120, 250, "frame_b");
    pix(120, 200, "old_top");
    pix(120, 263, "old_bot");
    pix(120, 300, "new_top_early");
    pix(5, VER_PIXELS, "no_latch_h5");
    pix(120, 200, "still_old");
    pix(0, VER_PIXELS, "latch300");
    pix(120, 300, "new_top");
    pix(120, 363, "new_bot");
    pix(120, 200, "old_gone");
    pix(120, 364, "below_new");

    // bottom clipping and no wrap to the top
    latch_ypos(570);
    pix(120, 570, "clip_top");
    pix(120, 599, "clip_last");
    pix(120, 600, "clip_blank");
    pix(100, 569, "clip_above");
    for (int r = 0; r <= 33; r++) pix(120, r, "no_wrap");
    latch_ypos(4095);
    for (int r = 0; r < 70; r += 3) pix(120, r, "ypos_max");
    pix(120, 599, "ypos_max_bot");

    // random pixels around a random rectangle
    for (int f = 0; f < 3; f++) begin
      latch_ypos($urandom_range(0, 620));
      for (int i = 0; i < 120; i++) begin
        h = $urandom_range(XPOS - 4, XPOS + WIDTH + 4);
        v = lat_m - 3 + $urandom_range(0, HEIGHT + 6);
        if (v < 0) v = 0;
        pix(h, v, "rand_region");
      end
    end

    pix(0, 0, "drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
